mem_responder: RTL and testbench

//  Memory-side responder for the pipeline data/instruction memory port (mem_read/mem_write/mem_resp).

---
 rtl/mem_responder_pkg.sv | 18 +
 rtl/mem_responder_array.sv | 41 ++++
 rtl/mem_responder.sv | 136 +++++++++++++
 tb/tb_mem_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder stand-in memory.
package mem_responder_pkg;

    localparam int MEM_WORD_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP,
        S_RECOVER
    } mresp_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } mem_op_t;

endpackage

// File: rtl/mem_responder_array.sv
// Word array behind mem_responder: synchronous byte-enabled write, registered read port.
module mem_responder_array
    import mem_responder_pkg::*;
#(
    parameter int IDX_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  rd_en_i,
    input  logic [IDX_WIDTH-1:0]  rd_idx_i,
    output logic [MEM_WORD_W-1:0] rdata_o,
    input  logic                  we_i,
    input  logic [IDX_WIDTH-1:0]  wr_idx_i,
    input  logic [MEM_WORD_W-1:0] wdata_i,
    input  logic [1:0]            be_i
);

    localparam int DEPTH = 2 ** IDX_WIDTH;

    logic [MEM_WORD_W-1:0] mem_q [DEPTH];
    logic [MEM_WORD_W-1:0] rdata_q;

    // Contents are deliberately not reset; only the read register is.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            if (be_i[0]) mem_q[wr_idx_i][7:0]  <= wdata_i[7:0];
            if (be_i[1]) mem_q[wr_idx_i][15:8] <= wdata_i[15:8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= mem_q[rd_idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder for the pipeline memory port.
// Optional MEM_STATS_EN adds saturating rd_count/wr_count completion counters.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int READ_LATENCY  = 3,
    parameter int WRITE_LATENCY = 3,
    parameter int IDX_WIDTH     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_wdata,
    input  logic [1:0]  mem_byte_enable,
    output logic [15:0] mem_rdata,
    output logic        mem_resp
`ifdef MEM_STATS_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
`endif
);

    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT);

    mresp_state_t          state_q;
    mem_op_t               op_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_WIDTH-1:0]  idx_q;
    logic [MEM_WORD_W-1:0] wdata_q;
    logic [1:0]            be_q;
    logic                  resp_q;

    logic [IDX_WIDTH-1:0]  req_idx;
    logic                  busy_last;
    logic                  rd_en;
    logic [IDX_WIDTH-1:0]  rd_idx;
    logic                  we;
    int unsigned           req_lat;

    logic unused_addr;
    assign unused_addr = ^{mem_address[0], mem_address >> (IDX_WIDTH + 1)};

    assign req_idx   = mem_address[IDX_WIDTH:1];
    assign busy_last = (cnt_q <= CNT_W'(1));
    assign req_lat   = mem_read ? READ_LATENCY : WRITE_LATENCY;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            resp_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            resp_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (mem_read || mem_write) begin
                        op_q    <= mem_read ? OP_READ : OP_WRITE;
                        idx_q   <= req_idx;
                        wdata_q <= mem_wdata;
                        be_q    <= mem_byte_enable;
                        if (req_lat == 1) begin
                            state_q <= S_RESP;
                            resp_q  <= 1'b1;
                        end else begin
                            state_q <= S_BUSY;
                            cnt_q   <= CNT_W'(req_lat - 1);
                        end
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (busy_last) begin
                        state_q <= S_RESP;
                        resp_q  <= 1'b1;
                    end
                end
                S_RESP:    state_q <= S_RECOVER;
                S_RECOVER: state_q <= S_IDLE;
                default:   state_q <= S_IDLE;
            endcase
        end
    end

    // The read is launched one cycle early so the registered array output lands in S_RESP.
    always_comb begin
        rd_en  = 1'b0;
        rd_idx = idx_q;
        if (state_q == S_IDLE) begin
            rd_idx = req_idx;
            rd_en  = mem_read && (READ_LATENCY == 1);
        end else if (state_q == S_BUSY) begin
            rd_en = (op_q == OP_READ) && busy_last;
        end
    end

    assign we = (state_q == S_RESP) && (op_q == OP_WRITE) && !reset;

    mem_responder_array #(
        .IDX_WIDTH(IDX_WIDTH)
    ) u_array (
        .clk_i   (clk),
        .reset_i (reset),
        .rd_en_i (rd_en),
        .rd_idx_i(rd_idx),
        .rdata_o (mem_rdata),
        .we_i    (we),
        .wr_idx_i(idx_q),
        .wdata_i (wdata_q),
        .be_i    (be_q)
    );

    assign mem_resp = resp_q;

`ifdef MEM_STATS_EN
    logic [31:0] rd_count_q;
    logic [31:0] wr_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else if (state_q == S_RESP) begin
            if (op_q == OP_READ && rd_count_q != '1) rd_count_q <= rd_count_q + 32'd1;
            if (op_q == OP_WRITE && wr_count_q != '1) wr_count_q <= wr_count_q + 32'd1;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed table, corner sequences, random traffic.
module tb_mem_responder;

    localparam int RL = 3;
    localparam int WL = 3;
    localparam int IW = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_rdata;
    logic        mem_resp;
`ifdef MEM_STATS_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
`endif

    always #5 clk = ~clk;

    mem_responder #(
        .READ_LATENCY (RL),
        .WRITE_LATENCY(WL),
        .IDX_WIDTH    (IW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_byte_enable(mem_byte_enable),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp)
`ifdef MEM_STATS_EN
        ,
        .rd_count       (rd_count),
        .wr_count       (wr_count)
`endif
    );

    int errors = 0;
    int checks = 0;
    int exp_rd = 0;
    int exp_wr = 0;
    logic [15:0] model [2**IW];

    typedef struct {
        bit          rd;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int widx(input logic [15:0] addr);
        return (int'(addr) / 2) % (2**IW);
    endfunction

    task automatic model_write(input logic [15:0] addr, input logic [15:0] wdata, input logic [1:0] be);
        int i;
        i = widx(addr);
        if (be[0]) model[i][7:0]  = wdata[7:0];
        if (be[1]) model[i][15:8] = wdata[15:8];
    endtask

    // One complete transaction; the request is held until mem_resp unless pulse is set.
    task automatic access(input string name, input bit rd, input bit wr, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [1:0] be, input bit pulse);
        int lat;
        int exp_lat;
        exp_lat = rd ? RL : WL;
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; mem_address = addr;
        mem_wdata = wdata; mem_byte_enable = be;
        lat = -1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (pulse) begin
                mem_read = 1'b0; mem_write = 1'b0;
                mem_address = 16'($urandom); mem_wdata = 16'($urandom);
                mem_byte_enable = 2'($urandom);
            end
            if (mem_resp) begin
                lat = k;
                break;
            end
        end
        mem_read = 1'b0; mem_write = 1'b0;
        check({name, " latency"}, lat, exp_lat);
        if (lat > 0) begin
            if (rd) begin
                check({name, " rdata"}, {16'h0, mem_rdata}, {16'h0, model[widx(addr)]});
                exp_rd++;
            end else begin
                model_write(addr, wdata, be);
                exp_wr++;
            end
            @(posedge clk); #1;
            check({name, " pulse width"}, {31'h0, mem_resp}, 32'h0);
        end
    endtask

    initial begin
        int lat;
        int gap;
        logic [15:0] old;
        bit rd, wr;

        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        mem_address = '0; mem_wdata = '0; mem_byte_enable = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset resp", {31'h0, mem_resp}, 32'h0);
        check("reset rdata", {16'h0, mem_rdata}, 32'h0);
`ifdef MEM_STATS_EN
        check("reset rd_count", rd_count, 32'h0);
        check("reset wr_count", wr_count, 32'h0);
`endif
        reset = 1'b0;

        for (int i = 0; i < 2**IW; i++)
            access("preload", 1'b0, 1'b1, 16'(i * 2), 16'($urandom), 2'b11, 1'b0);

        tbl[0] = '{1'b0, 1'b1, 16'h0020, 16'hBEEF, 2'b11, 16'h0000};
        tbl[1] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 16'hBEEF};
        tbl[2] = '{1'b0, 1'b1, 16'h0020, 16'h1234, 2'b01, 16'h0000};
        tbl[3] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 16'hBE34};
        tbl[4] = '{1'b0, 1'b1, 16'h0020, 16'h5678, 2'b10, 16'h0000};
        tbl[5] = '{1'b1, 1'b0, 16'h0021, 16'h0000, 2'b00, 16'h5634};
        tbl[6] = '{1'b0, 1'b1, 16'h0020, 16'hFFFF, 2'b00, 16'h0000};
        tbl[7] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 16'h5634};
        tbl[8] = '{1'b1, 1'b1, 16'h0220, 16'h0000, 2'b11, 16'h5634};
        tbl[9] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 16'h5634};
        for (int i = 0; i < 10; i++) begin
            access($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].addr,
                   tbl[i].wdata, tbl[i].be, 1'b0);
            if (tbl[i].rd)
                check($sformatf("vec%0d table rdata", i), {16'h0, mem_rdata}, {16'h0, tbl[i].exp});
        end

        // LDI: read held through the response while the address moves to the second word.
        @(posedge clk); #1;
        mem_read = 1'b1; mem_address = 16'h0020;
        lat = -1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (mem_resp) begin lat = k; break; end
        end
        check("ldi first latency", lat, RL);
        check("ldi first rdata", {16'h0, mem_rdata}, {16'h0, model[widx(16'h0020)]});
        mem_address = 16'h0040;
        gap = -1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (mem_resp) begin gap = k; break; end
        end
        check("ldi gap", gap, 5);
        check("ldi second rdata", {16'h0, mem_rdata}, {16'h0, model[widx(16'h0040)]});
        mem_read = 1'b0;
        exp_rd += 2;
        @(posedge clk); #1;

        access("withdrawn write", 1'b0, 1'b1, 16'h0030, 16'hAAAA, 2'b11, 1'b1);
        access("withdrawn readback", 1'b1, 1'b0, 16'h0030, 16'h0, 2'b00, 1'b0);
        check("withdrawn value", {16'h0, mem_rdata}, 32'h0000AAAA);

        // Reset during S_BUSY of a write.
        old = model[widx(16'h0020)];
        @(posedge clk); #1;
        mem_write = 1'b1; mem_address = 16'h0020; mem_wdata = ~old; mem_byte_enable = 2'b11;
        @(posedge clk); #1;
        mem_write = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_rd = 0; exp_wr = 0;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("abort resp c%0d", k), {31'h0, mem_resp}, 32'h0);
            @(posedge clk); #1;
        end
        check("abort rdata", {16'h0, mem_rdata}, 32'h0);
        access("abort readback", 1'b1, 1'b0, 16'h0020, 16'h0, 2'b00, 1'b0);
        check("abort word kept", {16'h0, mem_rdata}, {16'h0, old});

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 3))
                0, 1: begin rd = 1'b1; wr = 1'b0; end
                2:    begin rd = 1'b0; wr = 1'b1; end
                default: begin rd = 1'b1; wr = 1'b1; end
            endcase
            access($sformatf("rand%0d", n), rd, wr, 16'($urandom), 16'($urandom),
                   2'($urandom), 1'($urandom_range(0, 1)));
        end

`ifdef MEM_STATS_EN
        check("final rd_count", rd_count, exp_rd);
        check("final wr_count", wr_count, exp_wr);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
